uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized Rx, mid-bit sampling, 8 data bits LSB first, 1 stop bit.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN (default build is 8N1).
module uart_rx #(
    parameter int CLKS_PER_BIT = 694
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Rx,
    output logic [7:0] DataOut,
    output logic       DataValid,
    output logic       FrameErr,
    output logic       ParityErr,
    output logic       Busy
);

    localparam logic [9:0] HALF_RELOAD = 10'(CLKS_PER_BIT / 2 - 1);
    localparam logic [9:0] FULL_RELOAD = 10'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4,
        ST_BREAK = 3'd5
    } state_t;
`endif

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_sync1;
    logic       r_rxs;
    logic       r_rxs_prev;
    logic [9:0] r_cnt;
    logic [9:0] w_cnt_nxt;
    logic [2:0] r_bitcnt;
    logic [2:0] w_bitcnt_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic [7:0] r_data;
    logic [7:0] w_data_nxt;
    logic       r_valid;
    logic       w_valid_nxt;
    logic       r_ferr;
    logic       w_ferr_nxt;
    logic       r_busy;
    logic       w_tick;
`ifdef UART_RX_PARITY_EN
    logic       r_perr;
    logic       w_perr_nxt;
    logic       r_par_bad;
    logic       w_par_bad_nxt;
`endif

    assign w_tick = (r_cnt == 10'd0);

    // Synchronizer, edge-detect history and all FSM-owned registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1    <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
            r_state    <= ST_IDLE;
            r_cnt      <= 10'd0;
            r_bitcnt   <= 3'd0;
            r_shift    <= 8'h00;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr     <= 1'b0;
            r_par_bad  <= 1'b0;
`endif
        end else begin
            r_sync1    <= Rx;
            r_rxs      <= r_sync1;
            r_rxs_prev <= r_rxs;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_shift    <= w_shift_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_ferr     <= w_ferr_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
`ifdef UART_RX_PARITY_EN
            r_perr     <= w_perr_nxt;
            r_par_bad  <= w_par_bad_nxt;
`endif
        end
    end

    // Next-state, counter reload and output pulse decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_data_nxt   = r_data;
        w_valid_nxt  = 1'b0;
        w_ferr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_nxt    = 1'b0;
        w_par_bad_nxt = r_par_bad;
`endif
        case (r_state)
            ST_IDLE: begin
                if (r_rxs_prev && !r_rxs) begin
                    w_cnt_nxt    = HALF_RELOAD;
                    w_bitcnt_nxt = 3'd0;
                    w_state_nxt  = ST_START;
                end else begin
                    w_cnt_nxt    = 10'd0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (!r_rxs) begin
                        w_cnt_nxt   = FULL_RELOAD;
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 10'd1;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_nxt  = {r_rxs, r_shift[7:1]};
                    w_cnt_nxt    = FULL_RELOAD;
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 10'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_par_bad_nxt = r_rxs ^ even_parity(r_shift);
                    w_cnt_nxt     = FULL_RELOAD;
                    w_state_nxt   = ST_STOP;
                end else begin
                    w_cnt_nxt = r_cnt - 10'd1;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    if (r_rxs) begin
                        // Leaving at mid-stop-bit lets a back-to-back start bit be seen.
`ifdef UART_RX_PARITY_EN
                        if (r_par_bad) begin
                            w_perr_nxt = 1'b1;
                        end else begin
                            w_data_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
                        end
`else
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
`endif
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 10'd1;
                end
            end
            ST_BREAK: begin
                w_cnt_nxt = 10'd0;
                if (r_rxs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BREAK;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 10'd0;
            end
        endcase
    end

    assign DataOut   = r_data;
    assign DataValid = r_valid;
    assign FrameErr  = r_ferr;
    assign Busy      = r_busy;
`ifdef UART_RX_PARITY_EN
    assign ParityErr = r_perr;
`else
    assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 694 clocks per bit; honours UART_RX_PARITY_EN when defined.
module tb_uart_rx;
    localparam int CPB = 694;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Rx;
    logic [7:0] DataOut;
    logic       DataValid;
    logic       FrameErr;
    logic       ParityErr;
    logic       Busy;

    int errors = 0;
    int checks = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_perr = 0;
    int n_multi = 0;
    logic [7:0] log_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .Clk(Clk), .Reset(Reset), .Rx(Rx), .DataOut(DataOut), .DataValid(DataValid),
        .FrameErr(FrameErr), .ParityErr(ParityErr), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // Pulse monitor sampled on the inactive edge.
    always @(negedge Clk) begin
        if (DataValid) begin
            n_valid = n_valid + 1;
            log_q.push_back(DataOut);
        end
        if (FrameErr) n_ferr = n_ferr + 1;
        if (ParityErr) n_perr = n_perr + 1;
        if ((int'(DataValid) + int'(FrameErr) + int'(ParityErr)) > 1) n_multi = n_multi + 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        Rx = b;
        cycles(CPB);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop_bit);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_byte_par(input logic [7:0] d, input logic par_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par_bit);
        drive_bit(1'b1);
    endtask
`endif

    task automatic test_reset;
        Reset = 1'b1;
        Rx = 1'b1;
        cycles(4);
        checks++; if (DataOut !== 8'h00) begin errors++; $display("FAIL reset_dataout got=%h exp=00", DataOut); end
        checks++; if (DataValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", DataValid); end
        checks++; if (FrameErr !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", FrameErr); end
        checks++; if (ParityErr !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", ParityErr); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        Reset = 1'b0;
        cycles(10);
    endtask

    task automatic test_basic;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        send_byte(8'h55, 1'b1);
        cycles(2);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL basic_valid_count got=%0d exp=1", n_valid - v0); end
        checks++; if (DataOut !== 8'h55) begin errors++; $display("FAIL basic_dataout got=%h exp=55", DataOut); end
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL basic_ferr got=%0d exp=0", n_ferr - f0); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle got=%b exp=0", Busy); end
    endtask

    task automatic test_glitch;
        int v0, f0, p0, k;
        v0 = n_valid; f0 = n_ferr; p0 = n_perr;
        Rx = 1'b0;
        cycles(10);
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start got=%b exp=1", Busy); end
        cycles(90);
        Rx = 1'b1;
        k = 0;
        while (Busy && k < 347) begin
            cycles(1);
            k++;
        end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_timeout got=%b exp=0 after %0d cycles", Busy, k); end
        cycles(5);
        checks++; if ((n_valid - v0) + (n_ferr - f0) + (n_perr - p0) !== 0) begin
            errors++; $display("FAIL glitch_pulses got=%0d exp=0", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0));
        end
    endtask

    task automatic test_frame_err;
        int v0, f0;
        send_byte(8'h12, 1'b1);
        checks++; if (DataOut !== 8'h12) begin errors++; $display("FAIL ferr_prev_byte got=%h exp=12", DataOut); end
        v0 = n_valid; f0 = n_ferr;
        send_byte(8'hA3, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_count got=%0d exp=1", n_ferr - f0); end
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL ferr_no_valid got=%0d exp=0", n_valid - v0); end
        checks++; if (DataOut !== 8'h12) begin errors++; $display("FAIL ferr_dataout_kept got=%h exp=12", DataOut); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL ferr_break_busy got=%b exp=1", Busy); end
        drive_bit(1'b1);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ferr_break_exit got=%b exp=0", Busy); end
        send_byte(8'h5A, 1'b1);
        cycles(2);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL ferr_next_valid got=%0d exp=1", n_valid - v0); end
        checks++; if (DataOut !== 8'h5A) begin errors++; $display("FAIL ferr_next_data got=%h exp=5a", DataOut); end
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_count_final got=%0d exp=1", n_ferr - f0); end
    endtask

    task automatic test_back_to_back;
        int v0, s0;
        v0 = n_valid; s0 = log_q.size();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        cycles(2);
        checks++; if (n_valid - v0 !== 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", n_valid - v0); end
        if (log_q.size() >= s0 + 2) begin
            checks++; if (log_q[s0] !== 8'h00) begin errors++; $display("FAIL b2b_first got=%h exp=00", log_q[s0]); end
            checks++; if (log_q[s0+1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got=%h exp=ff", log_q[s0+1]); end
        end else begin
            checks++; errors++; $display("FAIL b2b_log got=%0d entries exp=2", log_q.size() - s0);
        end
    endtask

    task automatic test_reset_mid;
        int v0, f0;
        logic [7:0] d;
        v0 = n_valid; f0 = n_ferr;
        d = 8'h3C;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        Rx = d[4];
        cycles(CPB / 2);
        Reset = 1'b1;
        cycles(1);
        Reset = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", Busy); end
        checks++; if (DataOut !== 8'h00) begin errors++; $display("FAIL rst_mid_dataout got=%h exp=00", DataOut); end
        Rx = 1'b1;
        cycles(CPB / 2);
        drive_bit(1'b1);
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL rst_mid_no_pulse got=%0d exp=0", n_valid - v0); end
        send_byte(8'h81, 1'b1);
        cycles(2);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL rst_mid_next_valid got=%0d exp=1", n_valid - v0); end
        checks++; if (DataOut !== 8'h81) begin errors++; $display("FAIL rst_mid_next_data got=%h exp=81", DataOut); end
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL rst_mid_ferr got=%0d exp=0", n_ferr - f0); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int v0, p0;
        v0 = n_valid; p0 = n_perr;
        send_byte_par(8'h0F, 1'b1);
        cycles(2);
        checks++; if (n_perr - p0 !== 1) begin errors++; $display("FAIL par_bad_perr got=%0d exp=1", n_perr - p0); end
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL par_bad_valid got=%0d exp=0", n_valid - v0); end
        checks++; if (DataOut !== 8'h81) begin errors++; $display("FAIL par_bad_dataout got=%h exp=81", DataOut); end
        send_byte_par(8'h0F, 1'b0);
        cycles(2);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL par_good_valid got=%0d exp=1", n_valid - v0); end
        checks++; if (DataOut !== 8'h0F) begin errors++; $display("FAIL par_good_data got=%h exp=0f", DataOut); end
        checks++; if (n_perr - p0 !== 1) begin errors++; $display("FAIL par_good_perr got=%0d exp=1", n_perr - p0); end
    endtask
`endif

    task automatic test_final;
        checks++; if (n_multi !== 0) begin errors++; $display("FAIL pulse_exclusive got=%0d exp=0", n_multi); end
`ifndef UART_RX_PARITY_EN
        checks++; if (n_perr !== 0) begin errors++; $display("FAIL perr_tied_low got=%0d exp=0", n_perr); end
`endif
    endtask

    initial begin
        Reset = 1'b1;
        Rx = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_final();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
